// File: rtl/vga_fetch_scheduler_if.sv
// vga_fetch_scheduler_if: SRAM read port and pixel FIFO port of the VGA fetch scheduler
interface vga_fetch_scheduler_if #(parameter int ADDRBITS = 19);
  logic                O_vga_req;
  logic [ADDRBITS-1:0] O_vga_adr;
  logic [15:0]         I_vga_dat;
  logic                I_pix_pop;
  logic [15:0]         O_pix_dat;
  logic                O_pix_valid;
  modport master (output O_vga_req, O_vga_adr, O_pix_dat, O_pix_valid, input I_vga_dat, I_pix_pop);
  modport slave (input O_vga_req, O_vga_adr, O_pix_dat, O_pix_valid, output I_vga_dat, I_pix_pop);
endinterface

// File: rtl/vga_fetch_scheduler.sv
// vga_fetch_scheduler: VGA SRAM read scheduler with pixel FIFO; VGA_FETCH_DOUBLESCAN_EN fetches every line twice
module vga_fetch_scheduler #(
  parameter int ADDRBITS    = 19,
  parameter int LINE_WORDS  = 320,
  parameter int FRAME_LINES = 480,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_BURST   = 4
) (
  input  logic                I_wb_clk,
  input  logic                I_wb_rst_n,
  input  logic                I_enable,
  input  logic                I_frame_start,
  input  logic [ADDRBITS-1:0] I_base_adr,
  vga_fetch_scheduler_if.master bus,
  output logic                O_frame_done,
  output logic                O_underrun
);
`ifdef VGA_FETCH_DOUBLESCAN_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int LINES = PASSES * FRAME_LINES;
  localparam int TOTAL = LINES * LINE_WORDS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(LINE_WORDS + 1);
  localparam int LW = $clog2(LINES + 1);
  localparam int PW = $clog2(TOTAL + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(LINE_WORDS - 1);
  localparam logic [LW-1:0] END_LINE  = LW'(LINES);
  localparam logic [PW-1:0] LAST_PUSH = PW'(TOTAL - 1);
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST);
  localparam logic [AW+1:0] OCC_MAX   = (AW+2)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t              state;
  logic [ADDRBITS-1:0] adr_q, adr_inc;
  logic [WW-1:0]       word_q;
  logic [LW-1:0]       line_q, line_nxt;
  logic [BW-1:0]       burst_q, burst_nxt;
  logic [1:0]          infl_q, infl_nxt;
  logic [15:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wp, rp;
  logic [AW:0]         cnt, cnt_nxt;
  logic [AW+1:0]       occ;
  logic [PW-1:0]       pushes;
  logic                issue, push, pop, wrap, req_nxt;
`ifdef VGA_FETCH_DOUBLESCAN_EN
  logic [ADDRBITS-1:0] line_start_q;
  logic                pass_q;
`endif
  assign issue = bus.O_vga_req;
  assign push = infl_q[1];
  assign pop = bus.I_pix_pop && cnt != '0;
  assign wrap = issue && word_q == LAST_WORD;
  assign bus.O_vga_adr = adr_q;
  assign bus.O_pix_valid = cnt != '0;
  assign bus.O_pix_dat = bus.O_pix_valid ? mem[rp] : '0;
  // next-cycle request decision from the state that will hold after this edge
  always_comb begin
    cnt_nxt = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    infl_nxt = {infl_q[0], issue};
    burst_nxt = issue ? burst_q + BW'(1) : '0;
    line_nxt = wrap ? line_q + LW'(1) : line_q;
    adr_inc = adr_q + ADDRBITS'(2);
    occ = {1'b0, cnt_nxt} + {{(AW+1){1'b0}}, infl_nxt[0]} + {{(AW+1){1'b0}}, infl_nxt[1]};
    req_nxt = state == FETCH && I_enable && occ < OCC_MAX && line_nxt < END_LINE && burst_nxt < BURST_END;
  end
  // FIFO storage; words landing after a restart are written but never counted
  always_ff @(posedge I_wb_clk) begin
    if (push) mem[wp] <= bus.I_vga_dat;
  end
  // frame FSM, address/line counters, read tags and FIFO pointers
  always_ff @(posedge I_wb_clk) begin
    if (!I_wb_rst_n) begin
      state <= IDLE;
      bus.O_vga_req <= 1'b0;
      adr_q <= '0;
      word_q <= '0;
      line_q <= '0;
      burst_q <= '0;
      infl_q <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      pushes <= '0;
      O_frame_done <= 1'b0;
      O_underrun <= 1'b0;
`ifdef VGA_FETCH_DOUBLESCAN_EN
      line_start_q <= '0;
      pass_q <= 1'b0;
`endif
    end else if (I_frame_start) begin
      state <= FETCH;
      bus.O_vga_req <= I_enable;
      adr_q <= I_base_adr & ~ADDRBITS'(1);
      word_q <= '0;
      line_q <= '0;
      burst_q <= '0;
      infl_q <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      pushes <= '0;
      O_frame_done <= 1'b0;
      O_underrun <= 1'b0;
`ifdef VGA_FETCH_DOUBLESCAN_EN
      line_start_q <= I_base_adr & ~ADDRBITS'(1);
      pass_q <= 1'b0;
`endif
    end else begin
      bus.O_vga_req <= req_nxt;
      burst_q <= burst_nxt;
      infl_q <= infl_nxt;
      cnt <= cnt_nxt;
      line_q <= line_nxt;
      if (issue) word_q <= wrap ? '0 : word_q + WW'(1);
`ifdef VGA_FETCH_DOUBLESCAN_EN
      if (wrap) begin
        pass_q <= ~pass_q;
        adr_q <= pass_q ? adr_inc : line_start_q;
        if (pass_q) line_start_q <= adr_inc;
      end else if (issue) adr_q <= adr_inc;
`else
      if (issue) adr_q <= adr_inc;
`endif
      if (push) begin
        wp <= wp + AW'(1);
        pushes <= pushes + PW'(1);
        if (pushes == LAST_PUSH) begin
          state <= DONE;
          O_frame_done <= 1'b1;
        end
      end
      if (pop) rp <= rp + AW'(1);
      if (bus.I_pix_pop && cnt == '0) O_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// tb_vga_fetch_scheduler: directed bench with a queue-level model compared every cycle
module tb_vga_fetch_scheduler;
  localparam int AB = 19, LWD = 4, FL = 16, DEPTH = 16, MB = 4;
`ifdef VGA_FETCH_DOUBLESCAN_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int TOTAL = LWD * FL * PASSES;
  logic clk = 0, rst_n = 0, en = 0, fs = 0, pop = 0;
  logic [AB-1:0] base = '0;
  logic [15:0] dat;
  logic done, under;
  int checks = 0, failures = 0, cyc = 0;
  vga_fetch_scheduler_if #(.ADDRBITS(AB)) bus ();
  vga_fetch_scheduler #(.ADDRBITS(AB), .LINE_WORDS(LWD), .FRAME_LINES(FL), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .I_wb_clk(clk), .I_wb_rst_n(rst_n), .I_enable(en), .I_frame_start(fs), .I_base_adr(base),
    .bus(bus), .O_frame_done(done), .O_underrun(under));
  assign dat = {cyc[7:0], ~cyc[7:0] ^ 8'h3C};
  assign bus.I_vga_dat = dat;
  assign bus.I_pix_pop = pop;
  always #5 clk = ~clk;
  // read data changes away from the sampling edge
  always @(negedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask
  // model: request k goes to base + 2*(source word index), data lands two cycles later
  logic m_req = 0, m_inf0 = 0, m_inf1 = 0, m_done = 0, m_under = 0, m_fetch = 0;
  int m_k = 0, m_burst = 0, m_pushes = 0;
  logic [AB-1:0] m_base = '0;
  logic [15:0] m_q[$];
  function automatic logic [AB-1:0] exp_adr(input int k);
    int ol = k / LWD, w = k % LWD, sl = ol / PASSES;
    return m_base + AB'(2 * (sl * LWD + w));
  endfunction
  // model update on the same edge the DUT samples
  always @(posedge clk) begin
    bit emp;
    if (!rst_n) begin
      m_req = 0; m_inf0 = 0; m_inf1 = 0; m_done = 0; m_under = 0; m_fetch = 0;
      m_k = 0; m_burst = 0; m_pushes = 0; m_base = '0; m_q.delete();
    end else if (fs) begin
      m_base = base & ~AB'(1); m_k = 0; m_burst = 0; m_inf0 = 0; m_inf1 = 0;
      m_q.delete(); m_pushes = 0; m_done = 0; m_under = 0; m_fetch = 1; m_req = en;
    end else begin
      emp = m_q.size() == 0;
      if (pop && !emp) void'(m_q.pop_front());
      if (pop && emp) m_under = 1;
      if (m_inf1) begin
        m_q.push_back(dat);
        m_pushes++;
        if (m_pushes == TOTAL) begin m_done = 1; m_fetch = 0; end
      end
      if (m_req) begin m_k++; m_burst++; end else m_burst = 0;
      m_inf1 = m_inf0;
      m_inf0 = m_req;
      m_req = m_fetch && en && (m_q.size() + int'(m_inf0) + int'(m_inf1) < DEPTH) && m_k < TOTAL && m_burst < MB;
    end
  end
  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("req", bus.O_vga_req, m_req);
    if (m_req) chk("adr", bus.O_vga_adr, exp_adr(m_k));
    chk("valid", bus.O_pix_valid, m_q.size() != 0);
    chk("pixdat", bus.O_pix_dat, m_q.size() != 0 ? m_q[0] : 16'h0);
    chk("done", done, m_done);
    chk("under", under, m_under);
  end
  logic [AB-1:0] exp_fill [10];
  logic [AB-1:0] adrs [10];
  logic [9:0] pat;
  int nreq, first, vrise, bad, popped;
  bit prev, found, ok;
  initial begin
`ifdef VGA_FETCH_DOUBLESCAN_EN
    exp_fill = '{19'h100, 19'h102, 19'h104, 19'h106, 19'h100, 19'h102, 19'h104, 19'h106, 19'h108, 19'h10A};
`else
    exp_fill = '{19'h100, 19'h102, 19'h104, 19'h106, 19'h108, 19'h10A, 19'h10C, 19'h10E, 19'h110, 19'h112};
`endif
    repeat (3) @(negedge clk);
    chk("rst_req", bus.O_vga_req, 0);
    chk("rst_adr", bus.O_vga_adr, 0);
    chk("rst_valid", bus.O_pix_valid, 0);
    chk("rst_pixdat", bus.O_pix_dat, 0);
    chk("rst_done", done, 0);
    chk("rst_under", under, 0);
    rst_n = 1;
    @(negedge clk);
    pop = 1;
    @(negedge clk);
    pop = 0;
    chk("underrun_set", under, 1);
    chk("underrun_pixdat", bus.O_pix_dat, 0);
    base = 19'h00100; en = 1; fs = 1;
    @(negedge clk);
    fs = 0;
    nreq = 0; first = -1; vrise = -1; pat = '0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) chk("underrun_clear", under, 0);
      if (c <= 10) pat[10-c] = bus.O_vga_req;
      if (bus.O_vga_req) begin
        if (nreq < 10) adrs[nreq] = bus.O_vga_adr;
        nreq++;
        if (first < 0) first = c;
      end
      if (bus.O_pix_valid && vrise < 0) vrise = c;
    end
    chk("first_req_cycle", first, 1);
    chk("burst_pattern", pat, 10'b1111011110);
    chk("valid_rise", vrise, 4);
    chk("fill_requests", nreq, 16);
    for (int i = 0; i < 10; i++) chk("fill_adr", adrs[i], exp_fill[i]);
    pop = 1;
    repeat (6) @(negedge clk);
    en = 0; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.O_vga_req) bad++;
    end
    en = 1;
    chk("pause_requests", bad, 0);
    repeat (10) @(negedge clk);
    prev = 0; found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (bus.O_vga_req && prev) found = 1;
      prev = bus.O_vga_req;
    end
    chk("two_inflight_found", found, 1);
    fs = 1; base = 19'h7FFFD; pop = 0;
    @(negedge clk);
    fs = 0;
    chk("restart_adr", bus.O_vga_adr, 19'h7FFFC);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      chk("flush_valid", bus.O_pix_valid, 0);
      chk("restart_req", bus.O_vga_req, 1);
    end
    chk("wrap_adr", bus.O_vga_adr, 19'h00000);
    @(negedge clk);
    pop = 1; popped = 0; ok = 0;
    for (int c = 0; c < 800; c++) begin
      if (pop && bus.O_pix_valid) popped++;
      if (done && !bus.O_pix_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("frame_finished", ok, 1);
    chk("popped_words", popped, TOTAL);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.O_vga_req) bad++;
    end
    chk("post_done_requests", bad, 0);
    chk("done_held", done, 1);
    pop = 0; base = '0; fs = 1;
    @(negedge clk);
    fs = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_req", bus.O_vga_req, 0);
    chk("midrst_done", done, 0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_discard", bus.O_pix_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
